unsaved_cpu_cpu_debug_mem_sequencer: RTL

Sysclk-domain sequencer that turns the debug slave's decoded JTAG command strobes (`take_action_ocimem_a`, `take_no_action_ocimem_a`, `take_action_ocimem_b`, with `jdo`) into single-word accesses on the on-chip debug RAM. It shares the RAM's single port between the JTAG debugger and the CPU's debug-memory slave. It returns read data and status to the debug slave as `MonDReg`, `monitor_ready` and `monitor_error`, and sits between the debug slave sysclk logic and the OCI RAM.

---
 rtl/unsaved_cpu_cpu_debug_mem_sequencer_if.sv | 22 ++
 rtl/unsaved_cpu_cpu_debug_mem_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/unsaved_cpu_cpu_debug_mem_sequencer_if.sv
// CPU debug-memory slave handshake: req held until a one-cycle ack,
// read data valid only alongside ack.
interface unsaved_cpu_cpu_debug_mem_sequencer_if #(
    parameter int RAM_AW = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [RAM_AW-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/unsaved_cpu_cpu_debug_mem_sequencer.sv
// Shares the single-port OCI debug RAM between JTAG command strobes and the
// CPU debug-memory slave, returning JTAG results through MonDReg/monitor_*.
module unsaved_cpu_cpu_debug_mem_sequencer #(
    parameter int RAM_AW = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [37:0]                          jdo,
    input  logic                                 take_action_ocimem_a,
    input  logic                                 take_no_action_ocimem_a,
    input  logic                                 take_action_ocimem_b,
    unsaved_cpu_cpu_debug_mem_sequencer_if.slave cpu,
    output logic                                 ram_en,
    output logic                                 ram_we,
    output logic [RAM_AW-1:0]                    ram_addr,
    output logic [31:0]                          ram_wdata,
    input  logic [31:0]                          ram_rdata,
    output logic [31:0]                          MonDReg,
    output logic                                 monitor_ready,
    output logic                                 monitor_error
);

    typedef enum logic [2:0] {IDLE, J_ISSUE, J_DATA, C_ISSUE, C_DATA} state_t;
    typedef enum logic {GRANT_CPU, GRANT_JTAG} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q;
    logic              op_we_q;
    logic              jtag_pend_q;
    logic              jtag_we_q;
    logic [RAM_AW-1:0] mon_a_reg;

    logic jtag_busy, queue_req, accept_queue, overrun, accept_load;
    logic jtag_done, jtag_wins;

    // Only the address field and the read/write-data field of jdo are decoded.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jtag_busy    = jtag_pend_q || (state_q == J_ISSUE) || (state_q == J_DATA);
    assign queue_req    = (take_action_ocimem_a && jdo[34]) || take_no_action_ocimem_a
                          || take_action_ocimem_b;
    assign overrun      = queue_req && jtag_busy;
    assign accept_queue = queue_req && !jtag_busy;
    assign accept_load  = take_action_ocimem_a && !overrun;
    assign jtag_done    = ((state_q == J_ISSUE) && op_we_q) || (state_q == J_DATA);
    // On a tie the requester that did not win last time goes first.
    assign jtag_wins    = jtag_pend_q && (!cpu.cpu_req || last_grant_q == GRANT_CPU);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: each always_comb target is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (jtag_wins)        state_d = J_ISSUE;
                else if (cpu.cpu_req) state_d = C_ISSUE;
            end
            J_ISSUE: state_d = op_we_q ? IDLE : J_DATA;
            J_DATA:  state_d = IDLE;
            C_ISSUE: state_d = op_we_q ? IDLE : C_DATA;
            C_DATA:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        cpu.cpu_ack   = 1'b0;
        cpu.cpu_rdata = '0;
        case (state_q)
            J_ISSUE: begin
                ram_en    = 1'b1;
                ram_we    = op_we_q;
                ram_addr  = mon_a_reg;
                ram_wdata = MonDReg;
            end
            C_ISSUE: begin
                ram_en      = 1'b1;
                ram_we      = op_we_q;
                ram_addr    = cpu.cpu_addr;
                ram_wdata   = cpu.cpu_wdata;
                cpu.cpu_ack = op_we_q;
            end
            C_DATA: begin
                cpu.cpu_ack   = 1'b1;
                cpu.cpu_rdata = ram_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q  <= GRANT_CPU;
            op_we_q       <= 1'b0;
            jtag_pend_q   <= 1'b0;
            jtag_we_q     <= 1'b0;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == J_ISSUE) begin
                last_grant_q <= GRANT_JTAG;
                op_we_q      <= jtag_we_q;
            end else if (state_q == IDLE && state_d == C_ISSUE) begin
                last_grant_q <= GRANT_CPU;
                op_we_q      <= cpu.cpu_we;
            end

            // An explicit address load takes priority over the post-write increment.
            if (accept_load)
                mon_a_reg <= jdo[RAM_AW+9:10];
            else if (take_no_action_ocimem_a && accept_queue)
                mon_a_reg <= mon_a_reg + RAM_AW'(1);
            else if (state_q == J_ISSUE && op_we_q)
                mon_a_reg <= mon_a_reg + RAM_AW'(1);

            if (take_action_ocimem_b && accept_queue) MonDReg <= jdo[34:3];
            else if (state_q == J_DATA)               MonDReg <= ram_rdata;

            if (accept_queue) begin
                jtag_pend_q   <= 1'b1;
                jtag_we_q     <= take_action_ocimem_b;
                monitor_ready <= 1'b0;
            end else if (jtag_done) begin
                jtag_pend_q   <= 1'b0;
                monitor_ready <= 1'b1;
            end

            if (overrun)          monitor_error <= 1'b1;
            else if (accept_load) monitor_error <= 1'b0;
        end
    end

endmodule
